// File: rtl/rv32_pkg.sv
// Shared RV32 definitions for the writeback path: result-source encoding,
// load funct3 codes and default datapath widths.
package rv32_pkg;
   localparam int XLEN   = 32;
   localparam int REG_AW = 5;

   typedef enum logic [1:0] {
      WB_ALU  = 2'd0,
      WB_LOAD = 2'd1,
      WB_PC4  = 2'd2,
      WB_IMM  = 2'd3
   } wb_sel_e;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
endpackage

// File: rtl/load_extract.sv
// Combinational load-data aligner: picks byte/half/word from an aligned word,
// sign/zero-extends it and flags misaligned halfword/word accesses.
module load_extract
   import rv32_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] load_word,
   input  logic [1:0]      addr_lo,
   input  logic [2:0]      funct3,
   output logic [XLEN-1:0] value,
   output logic            misalign
);
   logic [7:0]  byte_v;
   logic [15:0] half_v;

   // Halfword select ignores addr_lo[0]; misaligned halves round down.
   assign byte_v = load_word[{addr_lo, 3'b000} +: 8];
   assign half_v = load_word[{addr_lo[1], 4'b0000} +: 16];

   always_comb begin
      value = '0;
      case (funct3)
         F3_LB:   value = {{(XLEN-8){byte_v[7]}}, byte_v};
         F3_LH:   value = {{(XLEN-16){half_v[15]}}, half_v};
         F3_LW:   value = load_word;
         F3_LBU:  value = {{(XLEN-8){1'b0}}, byte_v};
         F3_LHU:  value = {{(XLEN-16){1'b0}}, half_v};
         default: value = '0;
      endcase
   end

   assign misalign = ((funct3 == F3_LH || funct3 == F3_LHU) && addr_lo[0]) ||
                     ((funct3 == F3_LW) && (addr_lo != 2'b00));
endmodule

// File: rtl/wb_stage.sv
// RV32I writeback stage: one MEM/WB entry, result select, register-file write
// and bypass. Define WB_INSTRET_EN to build the 64-bit retired-instruction counter.
module wb_stage #(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_valid,
   output logic              mem_ready,
   input  logic              stall,
   input  logic              flush,
   input  logic [1:0]        wb_sel,
   input  logic [2:0]        funct3,
   input  logic [1:0]        addr_lo,
   input  logic [XLEN-1:0]   alu_res,
   input  logic [XLEN-1:0]   load_word,
   input  logic [XLEN-1:0]   pc_plus4,
   input  logic [XLEN-1:0]   imm,
   input  logic [REG_AW-1:0] rd_i,
   input  logic              reg_we_i,
   output logic              rf_en,
   output logic [REG_AW-1:0] rf_rd,
   output logic [XLEN-1:0]   rf_data,
   output logic              fwd_valid,
   output logic              misalign,
   output logic [63:0]       instret
);
   import rv32_pkg::*;

   logic              vld_q, we_q;
   wb_sel_e           sel_q;
   logic [2:0]        f3_q;
   logic [1:0]        alo_q;
   logic [XLEN-1:0]   alu_q, lw_q, pc4_q, imm_q;
   logic [REG_AW-1:0] rd_q;

   logic              capture, consume, ld_mis;
   logic [XLEN-1:0]   ld_val, result;

   assign mem_ready = !stall;
   assign capture   = mem_valid && mem_ready && !flush;
   // Gating with rst keeps a mid-operation reset from leaking a write.
   assign consume   = vld_q && !stall && !flush && rst;

   always_ff @(posedge clk) begin
      if (!rst) begin
         vld_q <= 1'b0;
         we_q  <= 1'b0;
         sel_q <= WB_ALU;
         f3_q  <= '0;
         alo_q <= '0;
         alu_q <= '0;
         lw_q  <= '0;
         pc4_q <= '0;
         imm_q <= '0;
         rd_q  <= '0;
      end else if (capture) begin
         vld_q <= 1'b1;
         we_q  <= reg_we_i;
         sel_q <= wb_sel_e'(wb_sel);
         f3_q  <= funct3;
         alo_q <= addr_lo;
         alu_q <= alu_res;
         lw_q  <= load_word;
         pc4_q <= pc_plus4;
         imm_q <= imm;
         rd_q  <= rd_i;
      end else if (flush || !stall) begin
         vld_q <= 1'b0;
      end
   end

   load_extract #(.XLEN(XLEN)) u_ext (
      .load_word (lw_q),
      .addr_lo   (alo_q),
      .funct3    (f3_q),
      .value     (ld_val),
      .misalign  (ld_mis)
   );

   always_comb begin
      result = alu_q;
      case (sel_q)
         WB_ALU:  result = alu_q;
         WB_LOAD: result = ld_val;
         WB_PC4:  result = pc4_q;
         WB_IMM:  result = imm_q;
      endcase
   end

   assign rf_en     = consume && we_q && (rd_q != '0);
   assign rf_rd     = rf_en ? rd_q : '0;
   assign rf_data   = rf_en ? result : '0;
   assign fwd_valid = rf_en;
   assign misalign  = consume && (sel_q == WB_LOAD) && ld_mis;

`ifdef WB_INSTRET_EN
   logic [63:0] cnt_q;

   always_ff @(posedge clk) begin
      if (!rst)         cnt_q <= '0;
      else if (consume) cnt_q <= cnt_q + 64'd1;
   end

   assign instret = cnt_q;
`else
   assign instret = '0;
`endif
endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- RV32I writeback stage and sole driver of the register-file write port (`en`/`rd`/`data`).
- Holds one MEM/WB pipeline entry with a valid/ready handshake toward the memory stage.
- Selects the result source and extracts/sign-extends load data.
- Issues exactly one register-file write per retired instruction and exports the same value as a bypass to decode.

Parameters:
- XLEN, 32, datapath width.
- REG_AW, 5, register address width.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous and active-low
- mem_valid  in  1  memory stage presents an instruction
- mem_ready  out  1  WB can accept; equals !stall
- stall  in  1  hold WB entry (downstream/debug hold)
- flush  in  1  kill the WB entry and any capture this cycle
- wb_sel  in  2  result source: 0 ALU, 1 LOAD, 2 PC+4, 3 IMM (LUI)
- funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- addr_lo  in  2  load address bits [1:0]
- alu_res  in  XLEN  ALU result
- load_word  in  XLEN  aligned 32-bit word from data memory
- pc_plus4  in  XLEN  link value
- imm  in  XLEN  U-type immediate
- rd_i  in  REG_AW  destination register
- reg_we_i  in  1  instruction writes rd
- rf_en  out  1  register-file write enable
- rf_rd  out  REG_AW  register-file write address
- rf_data  out  XLEN  register-file write data
- fwd_valid  out  1  bypass valid, same as rf_en
- misalign  out  1  consumed LH/LHU with addr_lo[0]=1, or LW with addr_lo!=0
- instret  out  64  retired-instruction count

Behaviour:
- Reset (rst=0 at an edge): wb_valid=0, all stored fields 0. Outputs after reset: rf_en=0, fwd_valid=0, misalign=0, rf_rd=0, rf_data=0, instret=0.
- Capture: at an edge with mem_valid && mem_ready && !flush, all inputs are registered and wb_valid is set to 1.
  - At an edge with !stall and no capture, wb_valid is cleared.
  - While stall=1, the entry is held unchanged.
  - mem_ready is combinational: mem_ready = !stall.
- Consume: an entry is consumed in a cycle where wb_valid && !stall && !flush.
- rf_en is 1 only in a consuming cycle with reg_we=1 and rd!=0. x0 is never written. The register file captures the write at the next edge.
- Latency: capture at edge N, rf_en/rf_data valid during cycle N+1, register file updated at edge N+1.
  - Back-to-back entries give one write per cycle.
- rf_rd and rf_data are combinational from the registered entry. When rf_en=0, they are 0.
- Load extraction (wb_sel=1):
  - Byte = load_word[8*addr_lo +: 8].
  - Half = load_word[16*addr_lo[1] +: 16]; addr_lo[0] is ignored.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - Undefined funct3 values (011, 110, 111) produce 0.
- Misaligned accesses still write the aligned-down result. misalign pulses for one cycle in the consuming cycle.
- Flush: kills the held entry (no write, no retire) and blocks a same-cycle capture. If flush and stall are both asserted, flush wins and wb_valid clears.
- A mid-operation reset discards the entry; no write occurs in that cycle.

Optional Feature:
- Macro: WB_INSTRET_EN.
- Defined: 64-bit instret increments by 1 on every consumed entry, including reg_we=0 entries such as stores and branches. It wraps from 2^64-1 to 0 and resets to 0.
- Undefined: instret is tied to 0 and no counter flops exist.

Decomposition:
- Shared package rv32_pkg holds:
  - wb_sel enum: WB_ALU, WB_LOAD, WB_PC4, WB_IMM.
  - funct3 load constants: F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU.
  - XLEN and REG_AW defaults.
- One natural sub-module, load_extract: purely combinational (load_word, addr_lo, funct3 -> XLEN value, misalign). It is reused by a future store-to-load path.

Test Plan:
- Reset then ALU op: rst=0 for 2 cycles, then release; wb_sel=0, alu_res=0x0000_1234, rd=5, reg_we=1 -> next cycle rf_en=1, rf_rd=5, rf_data=0x0000_1234, instret=1.
- Load sign handling: load_word=0x80FF_7F01.
  - LB with addr_lo=3 -> 0xFFFF_FF80.
  - LBU with addr_lo=2 -> 0x0000_00FF.
  - LH with addr_lo=2 -> 0xFFFF_80FF.
  - LHU with addr_lo=0 -> 0x0000_7F01.
- x0 suppression: rd=0, reg_we=1, alu_res=0xDEAD_BEEF -> rf_en=0 and rf_data=0; instret still increments.
- Stall hold: capture JAL (wb_sel=2, pc_plus4=0x104, rd=1), then stall=1 for 3 cycles -> mem_ready=0 and rf_en=0 throughout. On release, exactly one write of 0x104 to x1; instret +1.
- Flush: flush=1 while the entry is held and a new mem_valid is presented -> no write, no retire, and wb_valid=0 on the next cycle.
- Misalign: LW with addr_lo=2 -> misalign=1 for exactly one cycle; rf_data equals load_word.
